// File: rtl/bw_mul_wb_frontend.sv
// bw_mul_wb_frontend
// Wishbone classic slave in front of the 8x8 Baugh-Wooley signed multiplier.
// The SoC writes operands, the block drives them to the core, waits LATENCY
// cycles for the combinational product to settle, then captures it.
//
// Optional feature macro: BW_MUL_IRQ_EN (completion interrupt + STATUS.irq_en).
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone classic request
//   wbs_sel_i, wbs_adr_i      byte selects, byte address
//   wbs_dat_i / wbs_dat_o     write data / registered read data
//   wbs_ack_o                 one-cycle acknowledge
//   mul_a, mul_b              operands to the multiplier core
//   mul_p                     signed product from the core
//   irq                       completion interrupt (0 when feature disabled)
//
// Register map (word offset adr[3:2]):
//   0x0 OPER   R/W {16'b0, b, a}
//   0x4 RESULT R   sign-extended product, read clears done
//   0x8 STATUS R/W bit0 busy, bit1 done, bit2 overrun (W1C), bit8 irq_en
//   0xC COUNT  R   completed-operation count
module bw_mul_wb_frontend #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          LATENCY   = 2,
  parameter int          CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        irq
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_reg;
  logic [3:0]        timer_reg;
  logic [7:0]        a_reg;
  logic [7:0]        b_reg;
  logic [15:0]       result_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              done_reg;
  logic              overrun_reg;
  logic              ack_reg;
  logic [31:0]       dat_reg;

  logic        hit;
  logic        req;
  logic        wr;
  logic        rd;
  logic [1:0]  wofs;
  logic        oper_wr;
  logic        start;
  logic        capture;
  logic        busy;
  logic        irq_en_bit;
  logic [31:0] status_word;
  logic [31:0] rdata;

  assign hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // !ack keeps the acknowledge a single-cycle pulse even if the master
  // holds stb through the ack cycle.
  assign req  = wbs_cyc_i & wbs_stb_i & ~ack_reg & hit;
  assign wr   = req & wbs_we_i;
  assign rd   = req & ~wbs_we_i;
  assign wofs = wbs_adr_i[3:2];

  assign busy    = (state_reg == ST_WAIT);
  assign oper_wr = wr && (wofs == 2'd0);
  assign start   = oper_wr && !busy && (wbs_sel_i[1:0] != 2'b00);
  assign capture = busy && (timer_reg == 4'd0);

  assign status_word = {23'b0, irq_en_bit, 5'b0, overrun_reg, done_reg, busy};

  always_comb begin
    rdata = 32'h0;
    case (wofs)
      2'd0: rdata = {16'b0, b_reg, a_reg};
      2'd1: rdata = {{16{result_reg[15]}}, result_reg};
      2'd2: rdata = status_word;
      2'd3: rdata = 32'(count_reg);
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= 4'd0;
      a_reg       <= 8'h0;
      b_reg       <= 8'h0;
      result_reg  <= 16'h0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      ack_reg     <= 1'b0;
      dat_reg     <= 32'h0;
    end else begin
      ack_reg <= req;
      if (rd) dat_reg <= rdata;

      // RESULT read clears done; the capture below is written later so a
      // completion in the same cycle wins.
      if (rd && (wofs == 2'd1)) done_reg <= 1'b0;

      if (oper_wr && busy) overrun_reg <= 1'b1;
      if (wr && (wofs == 2'd2) && wbs_dat_i[2]) overrun_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (wbs_sel_i[0]) a_reg <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) b_reg <= wbs_dat_i[15:8];
            done_reg  <= 1'b0;
            timer_reg <= 4'(LATENCY - 1);
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (capture) begin
            result_reg <= mul_p;
            done_reg   <= 1'b1;
            count_reg  <= count_reg + CNT_W'(1);
            state_reg  <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - 4'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef BW_MUL_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  assign irq_en_bit = irq_en_reg;
  assign irq        = irq_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr && (wofs == 2'd2)) irq_en_reg <= wbs_dat_i[8];
      irq_reg <= done_reg & irq_en_reg;
    end
  end
`else
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign mul_a     = a_reg;
  assign mul_b     = b_reg;

  // Bus bits with no function in this register map.
  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

endmodule

// File: doc/bw_mul_wb_frontend.md
Name: bw_mul_wb_frontend

Overview:
- Wishbone classic slave that sits directly upstream of the 8x8 Baugh-Wooley signed multiplier core inside user_project_wrapper.
- Registers operands written by the management SoC and drives them to the core.
- Waits a fixed settle latency, then captures the 16-bit signed product and exposes result, status and an operation counter over Wishbone.
- Replaces the present direct wbs_dat_i/wbs_dat_o wiring with a proper handshaked register interface.

Parameters:
- BASE_ADDR, 32'h3000_0000: base address; decode uses wbs_adr_i[31:4] == BASE_ADDR[31:4].
- LATENCY, 2: cycles between operand update and product capture; legal range 1..15.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mul_a  out  8  operand A to multiplier core.
- mul_b  out  8  operand B to multiplier core.
- mul_p  in  16  signed product from multiplier core (combinational).
- irq  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Reset (synchronous, wb_rst_i high at a rising edge): wbs_ack_o=0, wbs_dat_o=0, mul_a=0, mul_b=0, irq=0, result=0, count=0, busy=0, done=0, overrun=0, FSM=IDLE.
- Reset asserted mid-operation aborts it: no capture, count not incremented.
- Request: cyc&stb&!ack sampled high in cycle N, with address decoded at word offset wbs_adr_i[3:2].
  - wbs_ack_o is high in cycle N+1 only: exactly one-cycle pulse, never back-to-back.
  - Read data is registered and valid with the ack.
  - Writes take effect at the edge ending cycle N.
  - Address outside the BASE_ADDR window: no ack, so the bus times out.
- Register map:
  - 0x0 OPER
    - W: a=dat[7:0] if sel[0]; b=dat[15:8] if sel[1]. Unselected byte keeps its old value. Starts an operation if at least one of sel[1:0] is set.
    - R: {16'b0, b, a}.
  - 0x4 RESULT
    - R: product sign-extended to 32 bits.
    - Read clears done. If done is being set in the same cycle as the read, set wins.
  - 0x8 STATUS
    - R: bit0 busy, bit1 done, bit2 overrun, bit8 irq_en.
    - W: bit2=1 clears overrun; bit8 writes irq_en; other bits ignored.
  - 0xC COUNT
    - R: zero-extended completed-operation count; wraps modulo 2^CNT_W.
    - Writes ignored.
- FSM:
  - IDLE: an OPER write starts an operation -> load operands, busy=1, done=0, timer=LATENCY-1, go to WAIT.
  - WAIT: timer decrements each cycle. At timer==0: result<=mul_p, done=1, busy=0, count+=1, go to IDLE.
  - Resulting timing: done and result are visible from cycle N+1+LATENCY.
- Boundary conditions:
  - OPER write while busy: acked, operands unchanged, operation not restarted, overrun=1.
  - OPER write with sel[1:0]=0: acked, no start.
  - Back-to-back operations: a new start is accepted in the cycle after capture.
  - RESULT read while busy: returns the previous result; done is unaffected.
  - mul_a/mul_b are driven from the operand registers and are stable throughout WAIT.

Optional Feature:
- Macro: BW_MUL_IRQ_EN.
- Defined: irq is registered and equals done & irq_en. It is high from the cycle after done sets until done clears. irq_en is read/write via STATUS bit8.
- Undefined: irq is tied 0; the irq_en flop is absent; STATUS bit8 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8, 0xC -> all return 0x00000000; each ack is one cycle wide.
- Write OPER 0x00000503 (sel=4'hF), poll STATUS until done=1 (expected LATENCY+1 cycles after the request) -> RESULT reads 0x0000000F; STATUS then reads 0x0; COUNT reads 1.
- OPER writes 0x0000FFFF, 0x00008080, 0x00007F80 in sequence, each followed by a RESULT read -> 0x00000001, 0x00004000, 0xFFFFC080 respectively; COUNT reads 3.
- Write OPER 0x00000202, then immediately write OPER 0x00000909 while busy -> RESULT reads 0x00000004; STATUS bit2=1; writing STATUS 0x4 clears overrun.
- Write OPER 0x00000A00 with sel=4'b0010 after a=0x03 is held -> mul_a=0x03, mul_b=0x0A, RESULT reads 0x0000001E; a write with sel=4'b0100 gives an ack but no start (busy stays 0).
- With BW_MUL_IRQ_EN defined: set irq_en, write OPER 0x00000302 -> irq rises one cycle after done; reading RESULT (0x00000006) drops irq. With the macro undefined, irq stays 0 throughout.
